// File: rtl/mc6847_row_prefetch_if.sv
// Video-RAM read bus between the row prefetch engine (master) and memory (slave).
interface mc6847_row_prefetch_if #(
    parameter int ADDR_W = 15
);
    logic              RD;
    logic [ADDR_W-1:0] DA;
    logic [7:0]        DD;

    modport master (output RD, output DA, input DD);
    modport slave  (input RD, input DA, output DD);
endinterface

// File: rtl/mc6847_row_prefetch.sv
// Double-buffered character-row fetch: fills the back bank from video RAM with
// per-byte mode bits while the pixel path reads the front bank.
module mc6847_row_prefetch #(
    parameter int ADDR_W   = 15,
    parameter int MAX_COLS = 64,
    parameter int RD_LAT   = 1,
    parameter int MODE_W   = 4,
    localparam int COL_W   = $clog2(MAX_COLS)
) (
    input  logic                    pixel_clock,
    input  logic                    reset,
    input  logic                    width_64,
    input  logic                    row_start,
    input  logic [ADDR_W-1:0]       row_base,
    input  logic [MODE_W-1:0]       mode_in,
    input  logic                    swap,
    mc6847_row_prefetch_if.master   mem,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    input  logic [COL_W-1:0]        rd_col,
    output logic [7:0]              rd_data,
    output logic [MODE_W-1:0]       rd_mode
);
    localparam int STG = RD_LAT - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [COL_W-1:0]  n_last, issue_cnt, wr_cnt;
    logic [STG:0]      vld_pipe;
    logic [MODE_W-1:0] mode_pipe [STG:0];
    logic [COL_W-1:0]  col_pipe  [STG:0];
    logic              front, fill_bank, swap_pend;
    logic [1:0]        bank_wide;
    logic [7+MODE_W:0] bank_mem [2][MAX_COLS];

    logic wr_en, last_wr, start_bank;

    assign wr_en      = vld_pipe[STG];
    assign last_wr    = wr_en && (wr_cnt == n_last);
    // A swap in the same idle cycle as row_start retires the front bank first,
    // so the fill targets the bank that is front right now.
    assign start_bank = swap ? front : ~front;

    always_ff @(posedge pixel_clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (row_start) state_nxt = ISSUE;
            ISSUE:   if (issue_cnt == n_last) state_nxt = DRAIN;
            DRAIN:   if (last_wr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.RD = 1'b0;
        mem.DA = '0;
        busy   = (state != IDLE);
        if (state == ISSUE) begin
            mem.RD = 1'b1;
            mem.DA = base_q + ADDR_W'(issue_cnt);
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            base_q    <= '0;
            n_last    <= '0;
            issue_cnt <= '0;
            wr_cnt    <= '0;
            vld_pipe  <= '0;
            front     <= 1'b0;
            fill_bank <= 1'b1;
            swap_pend <= 1'b0;
            bank_wide <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done        <= last_wr;
            vld_pipe[0] <= (state == ISSUE);
            for (int i = 1; i <= STG; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (state == ISSUE) issue_cnt <= issue_cnt + 1'b1;
            if (wr_en)          wr_cnt    <= wr_cnt + 1'b1;

            if (row_start) begin
                if (busy) begin
                    overrun <= 1'b1;
                end else begin
                    base_q                <= row_base;
                    n_last                <= width_64 ? COL_W'(63) : COL_W'(31);
                    issue_cnt             <= '0;
                    wr_cnt                <= '0;
                    fill_bank             <= start_bank;
                    bank_wide[start_bank] <= width_64;
                end
            end

            // A swap during a fetch waits and lands on the edge that raises done.
            if (!busy) begin
                if (swap) front <= ~front;
            end else if (swap || swap_pend) begin
                if (last_wr) begin
                    front     <= ~front;
                    swap_pend <= 1'b0;
                end else begin
                    swap_pend <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        mode_pipe[0] <= mode_in;
        col_pipe[0]  <= issue_cnt;
        for (int i = 1; i <= STG; i++) begin
            mode_pipe[i] <= mode_pipe[i-1];
            col_pipe[i]  <= col_pipe[i-1];
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (wr_en && !reset) bank_mem[fill_bank][col_pipe[STG]] <= {mem.DD, mode_pipe[STG]};
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            rd_data <= '0;
            rd_mode <= '0;
        end else if (!bank_wide[front] && (|rd_col[COL_W-1:5])) begin
            rd_data <= '0;
            rd_mode <= '0;
        end else begin
            {rd_data, rd_mode} <= bank_mem[front][rd_col];
        end
    end
endmodule

// File: tb/tb_mc6847_row_prefetch.sv
// Directed bench: u1 runs with RD_LAT=1, u3 with RD_LAT=3; each memory model returns DA[7:0].
module tb_mc6847_row_prefetch;
    logic        pixel_clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mode_in = 4'h0;
    logic        rs1 = 0, w1 = 0, sw1 = 0, rs3 = 0, w3 = 0, sw3 = 0;
    logic [14:0] base1 = '0, base3 = '0;
    logic [5:0]  rc1 = '0, rc3 = '0;
    logic        busy1, done1, ovr1, busy3, done3, ovr3;
    logic [7:0]  rdat1, rdat3;
    logic [3:0]  rmode1, rmode3;
    int          n_cmp = 0, n_bad = 0;

    always #5 pixel_clock = ~pixel_clock;

    mc6847_row_prefetch_if #(.ADDR_W(15)) bus1 ();
    mc6847_row_prefetch_if #(.ADDR_W(15)) bus3 ();

    logic [7:0] m1_q;
    logic [7:0] m3_q [3];
    always @(posedge pixel_clock) begin
        m1_q    <= bus1.DA[7:0];
        m3_q[0] <= bus3.DA[7:0];
        m3_q[1] <= m3_q[0];
        m3_q[2] <= m3_q[1];
    end
    assign bus1.DD = m1_q;
    assign bus3.DD = m3_q[2];

    mc6847_row_prefetch #(.ADDR_W(15), .MAX_COLS(64), .RD_LAT(1), .MODE_W(4)) u1 (
        .pixel_clock(pixel_clock), .reset(reset), .width_64(w1), .row_start(rs1),
        .row_base(base1), .mode_in(mode_in), .swap(sw1), .mem(bus1.master),
        .busy(busy1), .done(done1), .overrun(ovr1), .rd_col(rc1),
        .rd_data(rdat1), .rd_mode(rmode1));

    mc6847_row_prefetch #(.ADDR_W(15), .MAX_COLS(64), .RD_LAT(3), .MODE_W(4)) u3 (
        .pixel_clock(pixel_clock), .reset(reset), .width_64(w3), .row_start(rs3),
        .row_base(base3), .mode_in(mode_in), .swap(sw3), .mem(bus3.master),
        .busy(busy3), .done(done3), .overrun(ovr3), .rd_col(rc3),
        .rd_data(rdat3), .rd_mode(rmode3));

    task automatic step();
        @(posedge pixel_clock);
        #1;
    endtask

    function automatic logic [3:0] mode_for(int c);
        return (c % 2 == 0) ? 4'hF : 4'h0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        n_cmp++; if (bus1.RD !== 1'b0 || bus1.DA !== 15'h0) begin n_bad++; $display("FAIL reset_bus1 got RD=%0b DA=%h want 0/0", bus1.RD, bus1.DA); end
        n_cmp++; if ({busy1, done1, ovr1} !== 3'b000) begin n_bad++; $display("FAIL reset_flags1 got %b want 000", {busy1, done1, ovr1}); end
        n_cmp++; if (rdat1 !== 8'h00 || rmode1 !== 4'h0) begin n_bad++; $display("FAIL reset_rd1 got %h/%h want 00/0", rdat1, rmode1); end
        n_cmp++; if (bus3.RD !== 1'b0 || {busy3, done3, ovr3} !== 3'b000 || rdat3 !== 8'h00) begin n_bad++; $display("FAIL reset_u3 got RD=%0b flags=%b rd=%h want 0/000/00", bus3.RD, {busy3, done3, ovr3}, rdat3); end
        reset = 1'b0;
        step();
    endtask

    // Fetch a narrow row on u1 and check RD/DA/busy/done per cycle.
    task automatic run_u1_row(input string tag, input logic [14:0] base);
        logic [14:0] exp_da;
        rs1 = 1; base1 = base; w1 = 0;
        step();
        rs1 = 0;
        for (int c = 1; c <= 36; c++) begin
            mode_in = mode_for(c);
            exp_da  = 15'(base + 15'(c - 1));
            n_cmp++; if (bus1.RD !== (c <= 32)) begin n_bad++; $display("FAIL %s_rd c=%0d got %0b want %0b", tag, c, bus1.RD, (c <= 32)); end
            if (c <= 32) begin
                n_cmp++; if (bus1.DA !== exp_da) begin n_bad++; $display("FAIL %s_da c=%0d got %h want %h", tag, c, bus1.DA, exp_da); end
            end
            n_cmp++; if (busy1 !== (c <= 33)) begin n_bad++; $display("FAIL %s_busy c=%0d got %0b want %0b", tag, c, busy1, (c <= 33)); end
            n_cmp++; if (done1 !== (c == 34)) begin n_bad++; $display("FAIL %s_done c=%0d got %0b want %0b", tag, c, done1, (c == 34)); end
            step();
        end
    endtask

    task automatic test_basic();
        run_u1_row("basic", 15'h7000);
        sw1 = 1; step(); sw1 = 0;
        rc1 = 6'd5; step();
        n_cmp++; if (rdat1 !== 8'h05 || rmode1 !== 4'hF) begin n_bad++; $display("FAIL basic_col5 got %h/%h want 05/f", rdat1, rmode1); end
        rc1 = 6'd40; step();
        n_cmp++; if (rdat1 !== 8'h00 || rmode1 !== 4'h0) begin n_bad++; $display("FAIL basic_col40 got %h/%h want 00/0", rdat1, rmode1); end
        rc1 = 6'd31; step();
        n_cmp++; if (rdat1 !== 8'h1F || rmode1 !== 4'hF) begin n_bad++; $display("FAIL basic_col31 got %h/%h want 1f/f", rdat1, rmode1); end
        rc1 = 6'd0; step();
        n_cmp++; if (rdat1 !== 8'h00 || rmode1 !== 4'h0) begin n_bad++; $display("FAIL basic_col0 got %h/%h want 00/0", rdat1, rmode1); end
    endtask

    task automatic test_wrap_lat3();
        logic [14:0] exp_da;
        logic [7:0]  exp_d;
        logic [3:0]  exp_m;
        rs3 = 1; base3 = 15'h7FE0; w3 = 1;
        step();
        rs3 = 0;
        for (int c = 1; c <= 70; c++) begin
            mode_in = mode_for(c);
            exp_da  = 15'(15'h7FE0 + 15'(c - 1));
            n_cmp++; if (bus3.RD !== (c <= 64)) begin n_bad++; $display("FAIL wrap_rd c=%0d got %0b want %0b", c, bus3.RD, (c <= 64)); end
            if (c <= 64) begin
                n_cmp++; if (bus3.DA !== exp_da) begin n_bad++; $display("FAIL wrap_da c=%0d got %h want %h", c, bus3.DA, exp_da); end
            end
            n_cmp++; if (done3 !== (c == 68)) begin n_bad++; $display("FAIL wrap_done c=%0d got %0b want %0b", c, done3, (c == 68)); end
            step();
        end
        sw3 = 1; step(); sw3 = 0;
        for (int k = 0; k < 64; k++) begin
            rc3 = 6'(k);
            step();
            exp_d = 8'(8'hE0 + 8'(k));
            exp_m = (k % 2 == 1) ? 4'hF : 4'h0;
            n_cmp++; if (rdat3 !== exp_d || rmode3 !== exp_m) begin n_bad++; $display("FAIL wrap_read k=%0d got %h/%h want %h/%h", k, rdat3, rmode3, exp_d, exp_m); end
        end
    endtask

    task automatic test_swap_pending();
        logic [7:0] exp_d;
        rc1 = 6'd3; rs1 = 1; base1 = 15'h2080; w1 = 0;
        step();
        rs1 = 0;
        for (int c = 1; c <= 36; c++) begin
            mode_in = mode_for(c);
            sw1 = (c == 5);
            exp_d = (c <= 34) ? 8'h03 : 8'h83;
            n_cmp++; if (rdat1 !== exp_d) begin n_bad++; $display("FAIL pend_rd c=%0d got %h want %h", c, rdat1, exp_d); end
            n_cmp++; if (done1 !== (c == 34)) begin n_bad++; $display("FAIL pend_done c=%0d got %0b want %0b", c, done1, (c == 34)); end
            step();
        end
        sw1 = 0;
        n_cmp++; if (ovr1 !== 1'b0) begin n_bad++; $display("FAIL pend_ovr got %0b want 0", ovr1); end
    endtask

    task automatic test_same_cycle();
        rc1 = 6'd3; rs1 = 1; sw1 = 1; base1 = 15'h30C0; w1 = 0;
        step();
        rs1 = 0; sw1 = 0;
        for (int c = 1; c <= 36; c++) begin
            mode_in = mode_for(c);
            if (c >= 2) begin
                n_cmp++; if (rdat1 !== 8'h03) begin n_bad++; $display("FAIL same_front c=%0d got %h want 03", c, rdat1); end
            end
            n_cmp++; if (done1 !== (c == 34)) begin n_bad++; $display("FAIL same_done c=%0d got %0b want %0b", c, done1, (c == 34)); end
            step();
        end
        sw1 = 1; step(); sw1 = 0; step();
        n_cmp++; if (rdat1 !== 8'hC3 || rmode1 !== 4'hF) begin n_bad++; $display("FAIL same_newbank got %h/%h want c3/f", rdat1, rmode1); end
    endtask

    task automatic test_overrun();
        logic [14:0] exp_da;
        rs1 = 1; base1 = 15'h1040; w1 = 0;
        step();
        rs1 = 0;
        for (int c = 1; c <= 36; c++) begin
            mode_in = mode_for(c);
            rs1 = (c == 10);
            if (c == 10) begin base1 = 15'h5555; w1 = 1; end
            exp_da = 15'(15'h1040 + 15'(c - 1));
            n_cmp++; if (bus1.RD !== (c <= 32)) begin n_bad++; $display("FAIL ovr_rd c=%0d got %0b want %0b", c, bus1.RD, (c <= 32)); end
            if (c <= 32) begin
                n_cmp++; if (bus1.DA !== exp_da) begin n_bad++; $display("FAIL ovr_da c=%0d got %h want %h", c, bus1.DA, exp_da); end
            end
            n_cmp++; if (ovr1 !== (c >= 11)) begin n_bad++; $display("FAIL ovr_flag c=%0d got %0b want %0b", c, ovr1, (c >= 11)); end
            n_cmp++; if (done1 !== (c == 34)) begin n_bad++; $display("FAIL ovr_done c=%0d got %0b want %0b", c, done1, (c == 34)); end
            step();
        end
        rs1 = 0; w1 = 0;
        sw1 = 1; step(); sw1 = 0;
        rc1 = 6'd40; step();
        n_cmp++; if (rdat1 !== 8'h00 || rmode1 !== 4'h0) begin n_bad++; $display("FAIL ovr_col40 got %h/%h want 00/0", rdat1, rmode1); end
        rc1 = 6'd2; step();
        n_cmp++; if (rdat1 !== 8'h42 || rmode1 !== 4'h0) begin n_bad++; $display("FAIL ovr_col2 got %h/%h want 42/0", rdat1, rmode1); end
    endtask

    task automatic test_mid_reset();
        n_cmp++; if (ovr1 !== 1'b1) begin n_bad++; $display("FAIL rst_ovr_sticky got %0b want 1", ovr1); end
        rs1 = 1; base1 = 15'h0100; w1 = 0;
        step();
        rs1 = 0;
        for (int c = 1; c <= 15; c++) begin
            mode_in = mode_for(c);
            reset = (c == 15);
            n_cmp++; if (bus1.RD !== 1'b1) begin n_bad++; $display("FAIL rst_pre_rd c=%0d got %0b want 1", c, bus1.RD); end
            step();
        end
        reset = 0;
        n_cmp++; if (busy1 !== 1'b0 || ovr1 !== 1'b0) begin n_bad++; $display("FAIL rst_flags got busy=%0b ovr=%0b want 0/0", busy1, ovr1); end
        for (int c = 16; c <= 40; c++) begin
            n_cmp++; if (bus1.RD !== 1'b0 || done1 !== 1'b0) begin n_bad++; $display("FAIL rst_quiet c=%0d got RD=%0b done=%0b want 0/0", c, bus1.RD, done1); end
            step();
        end
        run_u1_row("after_rst", 15'h0200);
        sw1 = 1; step(); sw1 = 0;
        rc1 = 6'd7; step();
        n_cmp++; if (rdat1 !== 8'h07 || rmode1 !== 4'hF) begin n_bad++; $display("FAIL rst_col7 got %h/%h want 07/f", rdat1, rmode1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_lat3();
        test_swap_pending();
        test_same_cycle();
        test_overrun();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
